cv_chk_seq: RTL

Receive-side checker for the 4-bit sequence generator. Samples the generator's SEQ code on each strobe and decodes it back to its position number. Infers the counting direction, tracks lock, and flags and counts any sample that breaks the expected step. It sits downstream of the generator, or at the far end of a link carrying SEQ, and provides the recovered NOM plus health status.

---
 rtl/cv_chk_seq_if.sv | 25 ++
 rtl/cv_chk_seq.sv | 108 ++++++++++
 2 files changed

// File: rtl/cv_chk_seq_if.sv
// Strobe/code bus between a SEQ source and the cv_chk_seq receive-side checker.
// The master drives the samples and clear; the slave returns the recovered position and health status.
interface cv_chk_seq_if #(
    parameter int unsigned CNT_W = 8
);
    logic             STB;
    logic             CLR;
    logic [3:0]       SEQ_I;
    logic [3:0]       NOM_O;
    logic             DIR;
    logic             LOCK;
    logic             ERR;
    logic             DIR_CHG;
    logic [CNT_W-1:0] ERR_CNT;

    modport master (
        output STB, CLR, SEQ_I,
        input  NOM_O, DIR, LOCK, ERR, DIR_CHG, ERR_CNT
    );

    modport slave (
        input  STB, CLR, SEQ_I,
        output NOM_O, DIR, LOCK, ERR, DIR_CHG, ERR_CNT
    );
endinterface

// File: rtl/cv_chk_seq.sv
// Receive-side checker for the 4-bit Gray sequence generator: decodes SEQ to NOM,
// infers the counting direction, tracks lock, and flags and counts broken steps.
module cv_chk_seq #(
    parameter int unsigned MISS_MAX = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic           CLK,
    input  logic           RST,
    cv_chk_seq_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

    localparam logic [3:0] MISS_LIM = 4'(MISS_MAX);

    state_t     state;
    logic [3:0] last;
    logic [3:0] miss;
    logic [3:0] d;
    logic [3:0] nxt;
    logic [3:0] prv;
    logic [3:0] exp_c;
    logic [3:0] rev_c;
    logic       rej;
    logic       miss_hit;

    always_comb begin
        d        = {bus.SEQ_I[3],
                    ^bus.SEQ_I[3:2],
                    ^bus.SEQ_I[3:1],
                    ^bus.SEQ_I[3:0]};
        nxt      = last + 4'd1;
        prv      = last - 4'd1;
        exp_c    = bus.DIR ? nxt : prv;
        rev_c    = bus.DIR ? prv : nxt;
        rej      = bus.STB && (state == TRACK) &&
                   (d != exp_c) && (d != last) && (d != rev_c);
        miss_hit = ((miss + 4'd1) == MISS_LIM);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            last        <= '0;
            miss        <= '0;
            bus.NOM_O   <= '0;
            bus.DIR     <= 1'b0;
            bus.LOCK    <= 1'b0;
            bus.ERR     <= 1'b0;
            bus.DIR_CHG <= 1'b0;
            bus.ERR_CNT <= '0;
        end else begin
            bus.ERR     <= 1'b0;
            bus.DIR_CHG <= 1'b0;

            // CLR wins over a same-cycle rejection; the count sticks at all-ones.
            if (bus.CLR)
                bus.ERR_CNT <= '0;
            else if (rej && (bus.ERR_CNT != '1))
                bus.ERR_CNT <= bus.ERR_CNT + CNT_W'(1);

            if (bus.STB) begin
                case (state)
                    IDLE: begin
                        last      <= d;
                        bus.NOM_O <= d;
                        state     <= ACQ;
                    end
                    ACQ: begin
                        bus.NOM_O <= d;
                        last      <= d;
                        if (d == nxt || d == prv) begin
                            bus.DIR  <= (d == nxt);
                            bus.LOCK <= 1'b1;
                            miss     <= '0;
                            state    <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (d == exp_c) begin
                            last      <= d;
                            bus.NOM_O <= d;
                            miss      <= '0;
                        end else if (d == rev_c) begin
                            last        <= d;
                            bus.NOM_O   <= d;
                            bus.DIR     <= ~bus.DIR;
                            bus.DIR_CHG <= 1'b1;
                            miss        <= '0;
                        end else if (rej) begin
                            bus.ERR <= 1'b1;
                            // The rejection that exhausts the miss budget re-seeds on this sample.
                            if (miss_hit) begin
                                state     <= ACQ;
                                bus.LOCK  <= 1'b0;
                                last      <= d;
                                bus.NOM_O <= d;
                                miss      <= '0;
                            end else begin
                                miss <= miss + 4'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
